// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared types and helpers for the VGA timing generator.
//   state_e      : controller state (IDLE / RUN / STOPPING)
//   DEF_*        : default 640x480@60 raster geometry
//   axis_total   : pixels (or lines) per axis period
//   sync_start/end : first/last count value at which sync is asserted
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    localparam int DEF_HACTIVE = 640;
    localparam int DEF_HFP     = 16;
    localparam int DEF_HSYNC   = 96;
    localparam int DEF_HBP     = 48;
    localparam int DEF_VACTIVE = 480;
    localparam int DEF_VFP     = 10;
    localparam int DEF_VSYNC   = 2;
    localparam int DEF_VBP     = 33;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync - 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: counts 0..TOTAL-1 while enabled, wraps to 0, and decodes
// the active and sync windows of the current count.
//   vclk_i    : pixel clock
//   rst_n_i   : async active-low reset (count -> 0)
//   en_i      : advance the count this cycle
//   cnt_o     : current count
//   last_o    : count == TOTAL-1
//   active_o  : count in [0, ACTIVE-1]
//   sync_o    : count in [SYNC_START, SYNC_END] (polarity applied by caller)
// ---------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int WIDTH      = 11,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 751,
    parameter int TOTAL      = 800
) (
    input  logic             vclk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o,
    output logic             active_o,
    output logic             sync_o
);

    localparam logic [WIDTH-1:0] LAST_C   = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] ACTIVE_C = WIDTH'(ACTIVE);
    localparam logic [WIDTH-1:0] SS_C     = WIDTH'(SYNC_START);
    localparam logic [WIDTH-1:0] SE_C     = WIDTH'(SYNC_END);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge vclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign last_o   = (cnt_q == LAST_C);
    assign active_o = (cnt_q < ACTIVE_C);
    assign sync_o   = (cnt_q >= SS_C) && (cnt_q <= SE_C);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing with one-line-ahead line-memory fetch requests.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | counters parked at (0,0), raster outputs at rest values
// RUN      | free-running raster, line-0 prefetch issued each frame end
// STOPPING | finishing current frame, no line-0 prefetch; -> IDLE at end
//
// Ports:
//   VCLK, RST_N        : pixel clock, async active-low reset
//   iEN                : run request (start/stop at frame boundary)
//   iLINE_ACK          : line memory finished loading requested line
//   iCLR_UNDERRUN      : clears the sticky underrun flag
//   oHSYNC/oVSYNC      : syncs, polarity from HSYNC_POL/VSYNC_POL
//   oDE, oH_ADDR/oV_ADDR : active video and pixel/line address (0 off DE)
//   oLINE_REQ/_Y       : one-cycle fetch pulse and held line number
//   oFRAME_START       : pulse with the first DE cycle of a frame
//   oFRAME_CNT         : completed frames (wraps)
//   oUNDERRUN          : sticky late-ack flag
//   oRUNNING           : state != IDLE
//
// All raster outputs are registered decodes of the counters, so they lag
// the counter value by one clock. Line requests are aligned to the same
// stage, so a request shows up with the output of hcnt == HACTIVE.
// oFRAME_CNT and oLINE_REQ_Y keep their values through IDLE; only reset
// clears them.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int HACTIVE    = DEF_HACTIVE,
    parameter int HFP        = DEF_HFP,
    parameter int HSYNC      = DEF_HSYNC,
    parameter int HBP        = DEF_HBP,
    parameter int VACTIVE    = DEF_VACTIVE,
    parameter int VFP        = DEF_VFP,
    parameter int VSYNC      = DEF_VSYNC,
    parameter int VBP        = DEF_VBP,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  VCLK,
    input  logic                  RST_N,
    input  logic                  iEN,
    input  logic                  iLINE_ACK,
    input  logic                  iCLR_UNDERRUN,
    output logic                  oHSYNC,
    output logic                  oVSYNC,
    output logic                  oDE,
    output logic [ADDR_WIDTH-1:0] oH_ADDR,
    output logic [ADDR_WIDTH-1:0] oV_ADDR,
    output logic                  oLINE_REQ,
    output logic [ADDR_WIDTH-1:0] oLINE_REQ_Y,
    output logic                  oFRAME_START,
    output logic [FCNT_WIDTH-1:0] oFRAME_CNT,
    output logic                  oUNDERRUN,
    output logic                  oRUNNING
);

    localparam int HTOTAL   = axis_total(HACTIVE, HFP, HSYNC, HBP);
    localparam int VTOTAL   = axis_total(VACTIVE, VFP, VSYNC, VBP);
    localparam int HS_START = sync_start(HACTIVE, HFP);
    localparam int HS_END   = sync_end(HACTIVE, HFP, HSYNC);
    localparam int VS_START = sync_start(VACTIVE, VFP);
    localparam int VS_END   = sync_end(VACTIVE, VFP, VSYNC);

    localparam logic [ADDR_WIDTH-1:0] H_REQ_C = ADDR_WIDTH'(HACTIVE);
    localparam logic [ADDR_WIDTH-1:0] V_ACT_C = ADDR_WIDTH'(VACTIVE);
    localparam logic                  HS_ON   = (HSYNC_POL != 0);
    localparam logic                  VS_ON   = (VSYNC_POL != 0);

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] h_cnt, v_cnt, v_next;
    logic h_last, h_act, h_sync, v_last, v_act, v_sync;
    logic counting, h_wrap, frame_wrap, underrun_set;

    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] req_y_q, req_y_d;
    logic                  pending_q, pending_d;
    logic                  underrun_q, underrun_d;
    logic [FCNT_WIDTH-1:0] frame_cnt_q;
    logic                  de_q, hs_q, vs_q, fs_q;
    logic [ADDR_WIDTH-1:0] h_addr_q, v_addr_q;

    assign counting   = (state_q != IDLE);
    assign h_wrap     = counting && h_last;
    assign frame_wrap = h_wrap && v_last;
    assign v_next     = v_cnt + 1'b1;
    // A request always lands one line ahead of its line, so the last pixel
    // of the current line is the deadline for whatever is still pending.
    assign underrun_set = h_wrap && pending_q;

    vga_axis_counter #(
        .WIDTH      (ADDR_WIDTH),
        .ACTIVE     (HACTIVE),
        .SYNC_START (HS_START),
        .SYNC_END   (HS_END),
        .TOTAL      (HTOTAL)
    ) u_h_cnt (
        .vclk_i   (VCLK),
        .rst_n_i  (RST_N),
        .en_i     (counting),
        .cnt_o    (h_cnt),
        .last_o   (h_last),
        .active_o (h_act),
        .sync_o   (h_sync)
    );

    vga_axis_counter #(
        .WIDTH      (ADDR_WIDTH),
        .ACTIVE     (VACTIVE),
        .SYNC_START (VS_START),
        .SYNC_END   (VS_END),
        .TOTAL      (VTOTAL)
    ) u_v_cnt (
        .vclk_i   (VCLK),
        .rst_n_i  (RST_N),
        .en_i     (h_wrap),
        .cnt_o    (v_cnt),
        .last_o   (v_last),
        .active_o (v_act),
        .sync_o   (v_sync)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = 1'b0;
        req_y_d    = req_y_q;
        pending_d  = pending_q;
        underrun_d = underrun_q;

        case (state_q)
            IDLE: begin
                if (iEN) begin
                    state_d = RUN;
                    // first frame has no previous frame end to prefetch from
                    req_d   = 1'b1;
                    req_y_d = '0;
                end
            end
            RUN: begin
                if (!iEN) state_d = STOPPING;
            end
            STOPPING: begin
                if (iEN)             state_d = RUN;
                else if (frame_wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (counting && (h_cnt == H_REQ_C)) begin
            if (v_next < V_ACT_C) begin
                req_d   = 1'b1;
                req_y_d = v_next;
            end else if (v_last && (state_q == RUN)) begin
                req_d   = 1'b1;
                req_y_d = '0;
            end
        end

        if (iLINE_ACK)    pending_d = 1'b0;
        if (underrun_set) pending_d = 1'b0;
        if (req_d)        pending_d = 1'b1;

        if (iCLR_UNDERRUN) underrun_d = 1'b0;
        if (underrun_set)  underrun_d = 1'b1;
    end

    always_ff @(posedge VCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            req_y_q     <= '0;
            pending_q   <= 1'b0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            req_y_q    <= req_y_d;
            pending_q  <= pending_d;
            underrun_q <= underrun_d;
            if (frame_wrap) frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge VCLK or negedge RST_N) begin
        if (!RST_N) begin
            de_q     <= 1'b0;
            hs_q     <= ~HS_ON;
            vs_q     <= ~VS_ON;
            h_addr_q <= '0;
            v_addr_q <= '0;
            fs_q     <= 1'b0;
        end else if (counting) begin
            de_q     <= h_act && v_act;
            hs_q     <= h_sync ? HS_ON : ~HS_ON;
            vs_q     <= v_sync ? VS_ON : ~VS_ON;
            h_addr_q <= (h_act && v_act) ? h_cnt : '0;
            v_addr_q <= (h_act && v_act) ? v_cnt : '0;
            fs_q     <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            de_q     <= 1'b0;
            hs_q     <= ~HS_ON;
            vs_q     <= ~VS_ON;
            h_addr_q <= '0;
            v_addr_q <= '0;
            fs_q     <= 1'b0;
        end
    end

    assign oHSYNC       = hs_q;
    assign oVSYNC       = vs_q;
    assign oDE          = de_q;
    assign oH_ADDR      = h_addr_q;
    assign oV_ADDR      = v_addr_q;
    assign oLINE_REQ    = req_q;
    assign oLINE_REQ_Y  = req_y_q;
    assign oFRAME_START = fs_q;
    assign oFRAME_CNT   = frame_cnt_q;
    assign oUNDERRUN    = underrun_q;
    assign oRUNNING     = counting;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench on a 16x8 raster (HACTIVE=8, HFP=2, HSYNC=3, HBP=3,
// VACTIVE=4, VFP=1, VSYNC=2, VBP=1). Output index n counts registered
// outputs since the first decoded cycle: hcnt = n%16, vcnt = (n/16)%8.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic        VCLK = 1'b0;
    logic        RST_N;
    logic        iEN;
    logic        iLINE_ACK;
    logic        iCLR_UNDERRUN;
    logic        oHSYNC, oVSYNC, oDE;
    logic [10:0] oH_ADDR, oV_ADDR, oLINE_REQ_Y;
    logic        oLINE_REQ, oFRAME_START, oUNDERRUN, oRUNNING;
    logic [15:0] oFRAME_CNT;

    always #5 VCLK = ~VCLK;

    vga_timing_gen #(
        .ADDR_WIDTH (11),
        .HACTIVE    (8),
        .HFP        (2),
        .HSYNC      (3),
        .HBP        (3),
        .VACTIVE    (4),
        .VFP        (1),
        .VSYNC      (2),
        .VBP        (1),
        .HSYNC_POL  (0),
        .VSYNC_POL  (0),
        .FCNT_WIDTH (16)
    ) dut (
        .VCLK          (VCLK),
        .RST_N         (RST_N),
        .iEN           (iEN),
        .iLINE_ACK     (iLINE_ACK),
        .iCLR_UNDERRUN (iCLR_UNDERRUN),
        .oHSYNC        (oHSYNC),
        .oVSYNC        (oVSYNC),
        .oDE           (oDE),
        .oH_ADDR       (oH_ADDR),
        .oV_ADDR       (oV_ADDR),
        .oLINE_REQ     (oLINE_REQ),
        .oLINE_REQ_Y   (oLINE_REQ_Y),
        .oFRAME_START  (oFRAME_START),
        .oFRAME_CNT    (oFRAME_CNT),
        .oUNDERRUN     (oUNDERRUN),
        .oRUNNING      (oRUNNING)
    );

    int         checks   = 0;
    int         failures = 0;
    int         ack_dly  = 0;
    logic [3:0] withhold = 4'b0000;
    int         de_seen, fs_seen;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after
    // the edge. Line memory model: ack 2 cycles after a request unless that
    // line is in the withhold mask.
    task automatic step();
        @(posedge VCLK);
        #1;
        iLINE_ACK = 1'b0;
        if (ack_dly > 0) begin
            ack_dly--;
            if (ack_dly == 0) iLINE_ACK = 1'b1;
        end
        if (oLINE_REQ && !withhold[oLINE_REQ_Y[1:0]]) ack_dly = 2;
    endtask

    task automatic check_out(input int n, input int y0_ok, input int exp_unr,
                             input int exp_run, input int fbase);
        int h, v, de, req, ry;
        h   = n % 16;
        v   = (n / 16) % 8;
        de  = (h < 8 && v < 4) ? 1 : 0;
        req = (h == 8 && (v < 3 || (v == 7 && y0_ok != 0))) ? 1 : 0;
        ry  = (v < 3) ? v + 1 : 0;
        check_eq("de",          32'(oDE),          de);
        check_eq("hsync",       32'(oHSYNC),       (h >= 10 && h <= 12) ? 0 : 1);
        check_eq("vsync",       32'(oVSYNC),       (v >= 5 && v <= 6) ? 0 : 1);
        check_eq("h_addr",      32'(oH_ADDR),      (de != 0) ? h : 0);
        check_eq("v_addr",      32'(oV_ADDR),      (de != 0) ? v : 0);
        check_eq("frame_start", 32'(oFRAME_START), (n % 128 == 0) ? 1 : 0);
        check_eq("line_req",    32'(oLINE_REQ),    req);
        if (req != 0) check_eq("line_req_y", 32'(oLINE_REQ_Y), ry);
        check_eq("frame_cnt",   32'(oFRAME_CNT),   fbase + (n + 1) / 128);
        check_eq("underrun",    32'(oUNDERRUN),    exp_unr);
        check_eq("running",     32'(oRUNNING),     exp_run);
    endtask

    task automatic check_idle(input string tag, input int fexp, input int yexp);
        check_eq({tag, "_de"},      32'(oDE),          0);
        check_eq({tag, "_hsync"},   32'(oHSYNC),       1);
        check_eq({tag, "_vsync"},   32'(oVSYNC),       1);
        check_eq({tag, "_h_addr"},  32'(oH_ADDR),      0);
        check_eq({tag, "_v_addr"},  32'(oV_ADDR),      0);
        check_eq({tag, "_req"},     32'(oLINE_REQ),    0);
        check_eq({tag, "_fs"},      32'(oFRAME_START), 0);
        check_eq({tag, "_running"}, 32'(oRUNNING),     0);
        check_eq({tag, "_fcnt"},    32'(oFRAME_CNT),   fexp);
        check_eq({tag, "_req_y"},   32'(oLINE_REQ_Y),  yexp);
    endtask

    task automatic check_start(input string tag);
        check_eq({tag, "_req"},     32'(oLINE_REQ),   1);
        check_eq({tag, "_req_y"},   32'(oLINE_REQ_Y), 0);
        check_eq({tag, "_running"}, 32'(oRUNNING),    1);
        check_eq({tag, "_de"},      32'(oDE),         0);
    endtask

    initial begin
        RST_N         = 1'b0;
        iEN           = 1'b0;
        iLINE_ACK     = 1'b0;
        iCLR_UNDERRUN = 1'b0;

        // reset and idle
        repeat (2) @(posedge VCLK);
        #1;
        check_idle("rst", 0, 0);
        check_eq("rst_underrun", 32'(oUNDERRUN), 0);
        RST_N = 1'b1;
        step();
        step();
        check_idle("idle", 0, 0);

        // start: line-0 request on the transition, first DE two edges later
        iEN = 1'b1;
        step();
        check_start("start");

        // two clean frames with acks returned promptly
        de_seen = 0;
        fs_seen = 0;
        for (int n = 0; n < 256; n++) begin
            step();
            check_out(n, 1, 0, 1, 0);
            de_seen += int'(oDE);
            fs_seen += int'(oFRAME_START);
        end
        check_eq("de_cycles_2frames", de_seen, 64);
        check_eq("frame_starts_2frames", fs_seen, 2);

        // underrun: Y=2 never acked; Y=3 acked only at its deadline while
        // a clear is also asserted; then a lone clear
        withhold = 4'b1100;
        for (int n = 256; n < 384; n++) begin
            step();
            check_out(n, 1, (n >= 287 && n <= 304) ? 1 : 0, 1, 0);
            if (n == 302) begin
                iLINE_ACK     = 1'b1;
                iCLR_UNDERRUN = 1'b1;
            end
            if (n == 303) begin
                iCLR_UNDERRUN = 1'b0;
                withhold      = 4'b0000;
            end
            if (n == 304) iCLR_UNDERRUN = 1'b1;
            if (n == 305) iCLR_UNDERRUN = 1'b0;
        end

        // stop requested at line 1, hcnt 4: frame completes, no Y=0 prefetch
        for (int n = 384; n < 512; n++) begin
            step();
            check_out(n, 0, 0, (n < 511) ? 1 : 0, 0);
            if (n == 403) iEN = 1'b0;
        end
        step();
        step();
        check_idle("stopped", 4, 3);

        // restart from (0,0)
        iEN = 1'b1;
        step();
        check_start("restart");
        for (int n = 0; n <= 20; n++) begin
            step();
            check_out(n, 1, 0, 1, 4);
        end

        // async reset in the middle of an active pixel run
        #2;
        RST_N = 1'b0;
        #1;
        check_idle("async_rst", 0, 0);
        check_eq("async_rst_underrun", 32'(oUNDERRUN), 0);
        ack_dly = 0;
        step();
        RST_N = 1'b1;
        step();
        check_start("post_rst");
        for (int n = 0; n < 128; n++) begin
            step();
            check_out(n, 1, 0, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing (HSYNC, VSYNC, DE, H/V active addresses) for the downstream VGAout stage, which renders line memory into RGB.
- Issues a one-line-ahead fetch request per active line to the line-memory block that drives VGAout's iMEMOUT_* inputs, and flags late fetches as underrun.
- Supports clean start/stop at frame boundaries.

Parameters:
- ADDR_WIDTH, 11: width of the H/V counters and address outputs.
- HACTIVE, 640: active pixels per line.
- HFP, 16: horizontal front porch, in pixels.
- HSYNC, 96: horizontal sync width, in pixels.
- HBP, 48: horizontal back porch, in pixels.
- VACTIVE, 480: active lines per frame.
- VFP, 10: vertical front porch, in lines.
- VSYNC, 2: vertical sync width, in lines.
- VBP, 33: vertical back porch, in lines.
- HSYNC_POL, 0: HSYNC asserted level (0 = active-low).
- VSYNC_POL, 0: VSYNC asserted level (0 = active-low).
- FCNT_WIDTH, 16: frame counter width.

Ports:
- VCLK  in  1  pixel clock; the only clock.
- RST_N  in  1  asynchronous active-low reset.
- iEN  in  1  run request.
- iLINE_ACK  in  1  line memory reports the requested line is loaded.
- iCLR_UNDERRUN  in  1  clears oUNDERRUN.
- oHSYNC  out  1  horizontal sync, polarity per HSYNC_POL.
- oVSYNC  out  1  vertical sync, polarity per VSYNC_POL.
- oDE  out  1  active video.
- oH_ADDR  out  ADDR_WIDTH  pixel x; 0 when oDE=0.
- oV_ADDR  out  ADDR_WIDTH  line y; 0 when oDE=0.
- oLINE_REQ  out  1  one-cycle fetch request.
- oLINE_REQ_Y  out  ADDR_WIDTH  line to fetch; held until next request.
- oFRAME_START  out  1  one-cycle pulse aligned with the first DE cycle of a frame.
- oFRAME_CNT  out  FCNT_WIDTH  completed frames, wraps.
- oUNDERRUN  out  1  sticky late-ack flag.
- oRUNNING  out  1  state != IDLE.

Behaviour:
- Reset values:
  - All outputs 0, except oHSYNC = ~HSYNC_POL and oVSYNC = ~VSYNC_POL (deasserted).
  - Counters hcnt = vcnt = 0; state IDLE.
- Totals: HTOTAL = HACTIVE+HFP+HSYNC+HBP; VTOTAL = VACTIVE+VFP+VSYNC+VBP. Both must be < 2^ADDR_WIDTH.
- Horizontal layout: active [0, HACTIVE-1], then FP, then SYNC, then BP. Vertical layout is identical, in lines.
- Counters:
  - hcnt wraps at HTOTAL-1 to 0.
  - vcnt increments on each hcnt wrap and wraps at VTOTAL-1.
- All outputs are registered decodes of (hcnt, vcnt): latency is exactly 1 VCLK from counter value to output.
  - oDE = (hcnt < HACTIVE) && (vcnt < VACTIVE).
  - oH_ADDR = hcnt and oV_ADDR = vcnt when DE, else 0.
- State machine:
  - IDLE: counters held at 0,0; outputs at reset values. iEN=1 moves to RUN on the next edge, and counting starts from (0,0), so the first DE=1 output appears 2 edges after iEN is sampled high.
  - RUN: free-running. iEN=0 moves to STOPPING.
  - STOPPING: keeps counting. If iEN returns to 1, go back to RUN with no glitch. At hcnt=HTOTAL-1 and vcnt=VTOTAL-1, go to IDLE (the counters wrap to 0 and hold). A frame is never truncated.
- Line request:
  - Pulsed while in RUN or STOPPING at hcnt == HACTIVE, when the next line is active: Y = vcnt+1 if vcnt+1 < VACTIVE.
  - Also pulsed at vcnt == VTOTAL-1 with Y = 0 (prefetch for line 0), unless state is STOPPING.
  - Before the very first frame after IDLE, the line-0 request is issued on the IDLE->RUN transition cycle.
- Pending/underrun:
  - A pending flag is set by a request and cleared by iLINE_ACK; an ack with nothing pending is ignored.
  - If the flag is still pending at the cycle before that line's hcnt==0, set oUNDERRUN and drop pending.
  - oUNDERRUN clears only on iCLR_UNDERRUN. Set has priority if both occur in the same cycle.
- oFRAME_START: registered with the output at (0,0) in RUN or STOPPING.
- oFRAME_CNT: +1 at the VTOTAL-1 to 0 wrap; wraps modulo 2^FCNT_WIDTH.
- Async reset mid-frame: immediate return to reset values; pending and underrun cleared.

Decomposition:
- Shared package `vga_timing_pkg`:
  - state enum {IDLE, RUN, STOPPING}.
  - Localparams HTOTAL/VTOTAL and the sync start/end constants derived from the porch parameters.
- One sub-module `vga_axis_counter` (count, wrap, active/sync decode), instantiated twice: H, and V with increment-enable = H wrap.

Test Plan:
All scenarios use HACTIVE=8, HFP=2, HSYNC=3, HBP=3 (HTOTAL=16), VACTIVE=4, VFP=1, VSYNC=2, VBP=1 (VTOTAL=8).
1. Reset, then iEN=1 -> DE high for exactly 8 cycles per line on lines 0..3. HSYNC low for output hcnt 10..12. VSYNC low on lines 5..6. Frame period 128 cycles. oFRAME_START once per 128 cycles.
2. Addresses -> oH_ADDR sequence 0..7 during DE and 0 elsewhere; oV_ADDR 0..3; each oFRAME_CNT increments at the frame wrap.
3. iLINE_ACK returned 2 cycles after every request -> requests for Y=1,2,3 at hcnt=8 of lines 0..2, plus Y=0 at vcnt=7; oUNDERRUN stays 0.
4. Withhold the ack for Y=2 -> oUNDERRUN=1 before line 2 starts. Then assert iCLR_UNDERRUN and a new late ack in the same cycle -> oUNDERRUN remains 1; a lone clear afterwards -> 0.
5. Drop iEN at line 1, hcnt 4 -> frame completes; state IDLE after the (7,15) cycle; oRUNNING falls; no Y=0 request issued. Re-raise iEN -> restart at (0,0) with a fresh line-0 request.
6. Assert RST_N low mid-line with DE=1 -> all outputs reset asynchronously (before the next edge); after release, the sequence restarts per scenario 1.
